// File: rtl/trng_pkg.sv
// Purpose : shared types and constants for the TRNG sharing arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
package trng_pkg;

    localparam int TRNG_WORDS   = 8;     // 256-bit result / 32-bit words
    localparam int TRNG_ADDR_W  = 3;     // core read address width
    localparam int TRNG_TIMEOUT = 1023;  // default abort limit for the wait states
    localparam int TMO_W        = 10;    // timeout counter width

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KICK     = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_WAIT_HI  = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RD_CAP   = 3'd5,
        ST_HOLD     = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/trng_arbiter_if.sv
// Purpose : requester-side and core-side signal bundle of the TRNG arbiter.
// Latency : n/a (wires only).
// Backpressure: word_valid/word_ready on the requester side; trng_rdy gates the core side.
// master = arbiter view, slave = requesters + TRNG core view.
interface trng_arbiter_if #(
    parameter int NREQ = 4
);
    import trng_pkg::*;

    logic [NREQ-1:0]        req;         // per-requester request level
    logic [NREQ-1:0]        gnt;         // one-hot grant
    logic [31:0]            word_data;   // delivered word
    logic [TRNG_ADDR_W-1:0] word_idx;    // index of word_data
    logic                   word_valid;  // word_data/word_idx valid
    logic                   word_ready;  // granted consumer accepts word
    logic [NREQ-1:0]        done;        // end-of-operation pulse
    logic                   err;         // timeout abort pulse, with done
    logic                   trng_en;     // core start pulse
    logic                   trng_rd_en;  // core read strobe
    logic [TRNG_ADDR_W-1:0] trng_addr;   // core read address
    logic [31:0]            trng_out;    // core read data, one cycle after strobe
    logic                   trng_rdy;    // core idle with result valid

    modport master (
        input  req, word_ready, trng_out, trng_rdy,
        output gnt, word_data, word_idx, word_valid, done, err,
               trng_en, trng_rd_en, trng_addr
    );

    modport slave (
        output req, word_ready, trng_out, trng_rdy,
        input  gnt, word_data, word_idx, word_valid, done, err,
               trng_en, trng_rd_en, trng_addr
    );

endinterface

// File: rtl/trng_arbiter_rr_arbiter.sv
// Purpose : round-robin one-hot pick from req, starting at an internal pointer.
// Latency : pick is combinational; pointer updates one cycle after adv.
// Backpressure: none; caller decides when to consume the pick and when to advance.
// Ports: clk/rst_n, req (levels), adv + adv_idx (move pointer past adv_idx),
//        pick (one-hot, zero when no req), pick_idx (binary of pick).
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    input  logic [2:0]      adv_idx,
    output logic [NREQ-1:0] pick,
    output logic [2:0]      pick_idx
);

    logic [2:0] ptr;
    logic       found;

    // Two passes: first the bits at or above the pointer, then wrap to the
    // bits below it. The second pass only fires if the first found nothing.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr)) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_idx = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                pick[i]  = 1'b1;
                pick_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (adv_idx >= 3'(NREQ - 1)) ? 3'd0 : adv_idx + 3'd1;
        end
    end

endmodule

// File: rtl/trng_arbiter.sv
// Purpose : share one 256-bit TRNG core among NREQ requesters, round-robin.
// Latency : grant->kick 1 cycle; per word min 3 cycles (issue, capture, transfer).
// Backpressure: word_ready low holds the word and stalls further core reads.
// Ports: clk, rst_n (async active-low), bus (trng_arbiter_if.master):
//        requester side req/gnt/word_*/done/err, core side trng_*.
module trng_arbiter
    import trng_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WORDS   = TRNG_WORDS,
    parameter int TIMEOUT = TRNG_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    trng_arbiter_if.master bus
);

    localparam logic [TRNG_ADDR_W-1:0] LAST_WORD = TRNG_ADDR_W'(WORDS - 1);
    localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t                 state;
    logic [2:0]             gidx;
    logic [TRNG_ADDR_W-1:0] cnt;
    logic [TMO_W-1:0]       tmo;
    logic [NREQ-1:0]        pick;
    logic [2:0]             pick_idx;
    logic                   adv;
    logic                   req_g;

    // gnt is one-hot and frozen for the whole run, so masking gives req[granted].
    assign req_g = |(bus.req & bus.gnt);
    assign adv   = (state == ST_DONE);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req),
        .adv      (adv),
        .adv_idx  (gidx),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            gidx           <= '0;
            cnt            <= '0;
            tmo            <= '0;
            bus.gnt        <= '0;
            bus.word_data  <= '0;
            bus.word_idx   <= '0;
            bus.word_valid <= 1'b0;
            bus.done       <= '0;
            bus.err        <= 1'b0;
            bus.trng_en    <= 1'b0;
            bus.trng_rd_en <= 1'b0;
            bus.trng_addr  <= '0;
        end else begin
            // Strobes and pulses default low; states below raise them for one cycle.
            bus.trng_en    <= 1'b0;
            bus.trng_rd_en <= 1'b0;
            bus.done       <= '0;
            bus.err        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|bus.req && bus.trng_rdy) begin
                        bus.gnt     <= pick;
                        gidx        <= pick_idx;
                        bus.trng_en <= 1'b1;
                        state       <= ST_KICK;
                    end
                end

                ST_KICK: begin
                    tmo   <= '0;
                    state <= ST_WAIT_LO;
                end

                ST_WAIT_LO: begin
                    if (!bus.trng_rdy) begin
                        tmo   <= '0;
                        state <= ST_WAIT_HI;
                    end else if (tmo == TMO_LAST) begin
                        bus.done <= bus.gnt;
                        bus.err  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                ST_WAIT_HI: begin
                    if (bus.trng_rdy) begin
                        cnt            <= '0;
                        bus.trng_rd_en <= 1'b1;
                        bus.trng_addr  <= '0;
                        state          <= ST_RD_ISSUE;
                    end else if (tmo == TMO_LAST) begin
                        bus.done <= bus.gnt;
                        bus.err  <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                ST_RD_ISSUE: begin
                    state <= ST_RD_CAP;
                end

                ST_RD_CAP: begin
                    bus.word_data <= bus.trng_out;
                    bus.word_idx  <= cnt;
                    if (req_g) begin
                        bus.word_valid <= 1'b1;
                        state          <= ST_HOLD;
                    end else if (cnt == LAST_WORD) begin
                        // Requester gone: discard and keep draining the core.
                        bus.done <= bus.gnt;
                        state    <= ST_DONE;
                    end else begin
                        cnt            <= cnt + 1'b1;
                        bus.trng_addr  <= cnt + 1'b1;
                        bus.trng_rd_en <= 1'b1;
                        state          <= ST_RD_ISSUE;
                    end
                end

                ST_HOLD: begin
                    // A dropped request counts as acceptance so the run still ends.
                    if (bus.word_ready || !req_g) begin
                        bus.word_valid <= 1'b0;
                        if (cnt == LAST_WORD) begin
                            bus.done <= bus.gnt;
                            state    <= ST_DONE;
                        end else begin
                            cnt            <= cnt + 1'b1;
                            bus.trng_addr  <= cnt + 1'b1;
                            bus.trng_rd_en <= 1'b1;
                            state          <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    bus.gnt <= '0;
                    state   <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trng_arbiter.sv
// Purpose : directed, table-driven bench for trng_arbiter with a behavioural TRNG core.
// Latency : core drops rdy one cycle after en, raises it 24 cycles later.
// Backpressure: bench drives word_ready per vector (stall, drop) from the negedge.
module tb_trng_arbiter;

    logic clk;
    logic rst_n;

    trng_arbiter_if #(.NREQ(4)) bus ();

    trng_arbiter #(.NREQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural TRNG core ----------------
    logic        core_rdy = 1'b1;
    logic [31:0] core_dat = '0;
    int          busy     = 0;
    int          mop      = 0;   // number of operations started on the core
    bit          hang     = 1'b0;

    assign bus.trng_rdy = core_rdy;
    assign bus.trng_out = core_dat;

    function automatic logic [31:0] word_val(input int op, input logic [2:0] i);
        logic [7:0] i8;
        i8 = {5'd0, i};
        return {8'(op), 8'h5A, i8 * 8'h11, 8'hC3 ^ i8};
    endfunction

    always @(posedge clk) begin
        if (bus.trng_en) begin
            core_rdy <= 1'b0;
            busy     <= 24;
            mop      <= mop + 1;
        end else if (!core_rdy && !hang && busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) core_rdy <= 1'b1;
        end
        if (bus.trng_rd_en) core_dat <= word_val(mop, bus.trng_addr);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] rq, input int exp_g,
                          input bit hng, input bit exp_err, input int stall_idx,
                          input int stall_n, input int drop_idx, input int exp_words);
        int         en_cnt     = 0;
        int         rd_cnt     = 0;
        int         nwords     = 0;
        int         viol       = 0;
        int         unstable   = 0;
        int         after_drop = 0;
        int         stall_left;
        bit         dropped    = 1'b0;
        logic [3:0] sg         = '0;
        logic [3:0] sd         = '0;
        logic       se         = 1'b0;
        logic [31:0] hd        = '0;
        logic [2:0] hi         = '0;
        stall_left     = stall_n;
        hang           = hng;
        bus.req        = rq;
        bus.word_ready = 1'b1;
        for (int c = 0; c < 3000 && sd == 4'd0; c++) begin
            @(negedge clk);
            if (sg == 4'd0 && bus.gnt != 4'd0) sg = bus.gnt;
            if (bus.trng_en) en_cnt++;
            if (bus.trng_en && !bus.trng_rdy) viol++;
            if (bus.trng_rd_en) begin
                rd_cnt++;
                if (!bus.trng_rdy) viol++;
                if (bus.word_valid) viol++;
                if (bus.trng_addr != 3'(rd_cnt - 1)) viol++;
            end
            if (bus.err && bus.done == 4'd0) viol++;
            if (bus.done != 4'd0) begin
                sd = bus.done;
                se = bus.err;
            end
            if (dropped && bus.word_valid) after_drop++;
            bus.word_ready = 1'b1;
            if (bus.word_valid && !dropped) begin
                if (int'(bus.word_idx) == drop_idx) begin
                    bus.req        = 4'd0;
                    dropped        = 1'b1;
                    bus.word_ready = 1'b0;
                end else if (int'(bus.word_idx) == stall_idx && stall_left > 0) begin
                    if (stall_left != stall_n && (bus.word_data != hd || bus.word_idx != hi))
                        unstable++;
                    hd             = bus.word_data;
                    hi             = bus.word_idx;
                    stall_left--;
                    bus.word_ready = 1'b0;
                end else begin
                    check($sformatf("%s_idx%0d", tag, nwords), 32'(bus.word_idx), 32'(nwords));
                    check($sformatf("%s_dat%0d", tag, nwords), bus.word_data,
                          word_val(mop, 3'(nwords)));
                    nwords++;
                end
            end
        end
        bus.req        = 4'd0;
        bus.word_ready = 1'b0;
        check({tag, "_done_seen"}, 32'(sd != 4'd0), 32'd1);
        check({tag, "_gnt"}, 32'(sg), 32'(4'd1 << exp_g));
        check({tag, "_done"}, 32'(sd), 32'(4'd1 << exp_g));
        check({tag, "_err"}, 32'(se), 32'(exp_err));
        check({tag, "_en_cnt"}, 32'(en_cnt), 32'd1);
        check({tag, "_rd_cnt"}, 32'(rd_cnt), hng ? 32'd0 : 32'd8);
        check({tag, "_words"}, 32'(nwords), 32'(exp_words));
        check({tag, "_viol"}, 32'(viol), 32'd0);
        if (stall_n > 0) check({tag, "_stable"}, 32'(unstable), 32'd0);
        if (drop_idx >= 0) check({tag, "_after_drop"}, 32'(after_drop), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_gnt_clr"}, 32'(bus.gnt), 32'd0);
        if (hng) begin
            hang = 1'b0;
            repeat (30) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [3:0] rq;
        int         exp_g;
        bit         hng;
        bit         exp_err;
        int         stall_idx;
        int         stall_n;
        int         drop_idx;
        int         exp_words;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit found;
        // req, grant, hang, err, stall idx/len, drop idx, words delivered
        vecs[0] = '{4'b0001, 0, 1'b0, 1'b0, -1, 0, -1, 8};  // single requester
        vecs[1] = '{4'b1011, 1, 1'b0, 1'b0, -1, 0, -1, 8};  // round robin
        vecs[2] = '{4'b1011, 3, 1'b0, 1'b0, -1, 0, -1, 8};
        vecs[3] = '{4'b1011, 0, 1'b0, 1'b0, -1, 0, -1, 8};  // wraps back to 0
        vecs[4] = '{4'b0001, 0, 1'b0, 1'b0,  2, 5, -1, 8};  // stall on word 2
        vecs[5] = '{4'b0100, 2, 1'b1, 1'b1, -1, 0, -1, 0};  // core hangs
        vecs[6] = '{4'b0110, 1, 1'b0, 1'b0, -1, 0, -1, 8};  // accepted after abort
        vecs[7] = '{4'b0010, 1, 1'b0, 1'b0, -1, 0,  3, 3};  // drop in word 3 hold
        vecs[8] = '{4'b1111, 2, 1'b0, 1'b0, -1, 0, -1, 8};  // pointer moved to 2

        rst_n          = 1'b0;
        bus.req        = 4'd0;
        bus.word_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_gnt",   32'(bus.gnt), 32'd0);
        check("reset_valid", 32'(bus.word_valid), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_en",    32'({bus.trng_en, bus.trng_rd_en, bus.err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_op($sformatf("v%0d", v), vecs[v].rq, vecs[v].exp_g, vecs[v].hng,
                   vecs[v].exp_err, vecs[v].stall_idx, vecs[v].stall_n,
                   vecs[v].drop_idx, vecs[v].exp_words);
        end

        // Reset during the capture of word 5; pointer is 3 here, so req[2] wins.
        bus.req        = 4'b0100;
        bus.word_ready = 1'b1;
        found          = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (bus.trng_rd_en && bus.trng_addr == 3'd5) found = 1'b1;
        end
        check("rst_reach", 32'(found), 32'd1);
        check("rst_pre_gnt", 32'(bus.gnt), 32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_gnt",   32'(bus.gnt), 32'd0);
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_data",  bus.word_data, 32'd0);
        check("rst_idx",   32'(bus.word_idx), 32'd0);
        check("rst_core",  32'({bus.trng_en, bus.trng_rd_en, bus.trng_addr}), 32'd0);
        check("rst_done",  32'({bus.done, bus.err}), 32'd0);
        bus.req        = 4'd0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 4'b1111, 0, 1'b0, 1'b0, -1, 0, -1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
